cv_ctrl_port: RTL and testbench

Parametrised ColecoVision controller-port front end: it turns per-port packed keypad/joystick button vectors into the 9-pin port levels sampled by `cv_console`. Keypad select (p5) and joystick select (p8) are driven by the console. It generalises the fixed two-port combinational mapping to `NUM_PORTS` ports with registered outputs. It adds a Super Action / Roller style spinner: signed motion deltas are accumulated and replayed as rate-limited quadrature on p7/p9, with an interrupt pulse toward the CPU. It sits between the HPS/keyboard input merge in `emu` and the console.

---
 rtl/cv_ctrl_pkg.sv | 66 ++++++
 rtl/cv_spinner_quad.sv | 79 +++++++
 rtl/cv_ctrl_port.sv | 123 ++++++++++++
 tb/tb_cv_ctrl_port.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv_ctrl_pkg.sv
// cv_ctrl_pkg: ColecoVision controller key codes, keypad_i bit map
// and the keypad priority encoder shared by the port front end.
package cv_ctrl_pkg;

    localparam logic [3:0] CODE_0      = 4'b0011;
    localparam logic [3:0] CODE_1      = 4'b1110;
    localparam logic [3:0] CODE_2      = 4'b1101;
    localparam logic [3:0] CODE_3      = 4'b0110;
    localparam logic [3:0] CODE_4      = 4'b0001;
    localparam logic [3:0] CODE_5      = 4'b1001;
    localparam logic [3:0] CODE_6      = 4'b0111;
    localparam logic [3:0] CODE_7      = 4'b1100;
    localparam logic [3:0] CODE_8      = 4'b1000;
    localparam logic [3:0] CODE_9      = 4'b1011;
    localparam logic [3:0] CODE_STAR   = 4'b1010;
    localparam logic [3:0] CODE_HASH   = 4'b0101;
    localparam logic [3:0] CODE_PURPLE = 4'b0100;
    localparam logic [3:0] CODE_BLUE   = 4'b0010;
    localparam logic [3:0] CODE_NONE   = 4'b1111;

    localparam int unsigned KP_0      = 0;
    localparam int unsigned KP_1      = 1;
    localparam int unsigned KP_2      = 2;
    localparam int unsigned KP_3      = 3;
    localparam int unsigned KP_4      = 4;
    localparam int unsigned KP_5      = 5;
    localparam int unsigned KP_6      = 6;
    localparam int unsigned KP_7      = 7;
    localparam int unsigned KP_8      = 8;
    localparam int unsigned KP_9      = 9;
    localparam int unsigned KP_STAR   = 10;
    localparam int unsigned KP_HASH   = 11;
    localparam int unsigned KP_PURPLE = 12;
    localparam int unsigned KP_BLUE   = 13;
    localparam int unsigned KP_UP     = 14;
    localparam int unsigned KP_DOWN   = 15;
    localparam int unsigned KP_LEFT   = 16;
    localparam int unsigned KP_RIGHT  = 17;
    localparam int unsigned KP_FIRE   = 18;
    localparam int unsigned KP_ARM    = 19;

    // Lowest pressed key index wins when several keys are held.
    function automatic logic [3:0] kp_encode(input logic [19:0] kp);
        logic [3:0] code;
        code = CODE_NONE;
        priority case (1'b1)
            kp[KP_0]:      code = CODE_0;
            kp[KP_1]:      code = CODE_1;
            kp[KP_2]:      code = CODE_2;
            kp[KP_3]:      code = CODE_3;
            kp[KP_4]:      code = CODE_4;
            kp[KP_5]:      code = CODE_5;
            kp[KP_6]:      code = CODE_6;
            kp[KP_7]:      code = CODE_7;
            kp[KP_8]:      code = CODE_8;
            kp[KP_9]:      code = CODE_9;
            kp[KP_STAR]:   code = CODE_STAR;
            kp[KP_HASH]:   code = CODE_HASH;
            kp[KP_PURPLE]: code = CODE_PURPLE;
            kp[KP_BLUE]:   code = CODE_BLUE;
            default:       code = CODE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cv_spinner_quad.sv
// cv_spinner_quad: one port's spinner accumulator, step timer and
// quadrature phase; a_fall_o flags the step that drops A.
module cv_spinner_quad #(
    parameter int DELTA_W  = 8,
    parameter int ACC_W    = 10,
    parameter int STEP_DIV = 512
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      ce_i,
    input  logic signed [DELTA_W-1:0] delta_i,
    input  logic                      stb_i,
    output logic                      a_o,
    output logic                      b_o,
    output logic                      a_fall_o
);

    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SW = ((ACC_W > DELTA_W) ? ACC_W : DELTA_W) + 2;
    localparam logic signed [SW-1:0] ACC_MAX =
        {{(SW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [1:0]              ph_q, ph_d;

    logic                    nz, pos, step;
    logic signed [SW-1:0]    acc_x, dlt_x, stp, sum;

    always_comb begin
        nz    = |acc_q;
        pos   = ~acc_q[ACC_W-1];
        step  = ce_i && nz && (tmr_q == TW'(STEP_DIV - 1));
        acc_x = {{(SW - ACC_W){acc_q[ACC_W-1]}}, acc_q};
        dlt_x = {{(SW - DELTA_W){delta_i[DELTA_W-1]}}, delta_i};

        tmr_d = tmr_q;
        if (!nz)
            tmr_d = '0;
        else if (ce_i)
            tmr_d = step ? '0 : tmr_q + 1'b1;

        // Rotating {A,B} one place: forward 11-10-00-01, reverse the other way.
        ph_d = ph_q;
        if (step)
            ph_d = pos ? {ph_q[0], ~ph_q[1]} : {~ph_q[0], ph_q[1]};

        stp = '0;
        if (step)
            stp = pos ? SW'(1) : {SW{1'b1}};

        sum = stb_i ? (acc_x + dlt_x - stp) : (acc_x - stp);
        if (sum > ACC_MAX)
            acc_d = ACC_MAX[ACC_W-1:0];
        else if (sum < ACC_MIN)
            acc_d = ACC_MIN[ACC_W-1:0];
        else
            acc_d = sum[ACC_W-1:0];

        a_fall_o = step && ph_q[1] && !ph_d[1];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q <= '0;
            tmr_q <= '0;
            ph_q  <= 2'b11;
        end else begin
            acc_q <= acc_d;
            tmr_q <= tmr_d;
            ph_q  <= ph_d;
        end
    end

    assign a_o = ph_q[1];
    assign b_o = ph_q[0];

endmodule

// File: rtl/cv_ctrl_port.sv
// cv_ctrl_port: ColecoVision controller-port front end with registered lines.
// Define CV_SPINNER_EN to build the quadrature spinner and its interrupt.
module cv_ctrl_port #(
    parameter int NUM_PORTS = 2,
    parameter int DELTA_W   = 8,
    parameter int ACC_W     = 10,
    parameter int STEP_DIV  = 512
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           ce_i,
    input  logic [20*NUM_PORTS-1:0]        keypad_i,
    input  logic [DELTA_W*NUM_PORTS-1:0]   spin_delta_i,
    input  logic [NUM_PORTS-1:0]           spin_stb_i,
    input  logic [NUM_PORTS-1:0]           ctrl_p5_i,
    input  logic [NUM_PORTS-1:0]           ctrl_p8_i,
    output logic [NUM_PORTS-1:0]           ctrl_p1_o,
    output logic [NUM_PORTS-1:0]           ctrl_p2_o,
    output logic [NUM_PORTS-1:0]           ctrl_p3_o,
    output logic [NUM_PORTS-1:0]           ctrl_p4_o,
    output logic [NUM_PORTS-1:0]           ctrl_p6_o,
    output logic [NUM_PORTS-1:0]           ctrl_p7_o,
    output logic [NUM_PORTS-1:0]           ctrl_p9_o,
    output logic                           spin_int_n_o
);

    import cv_ctrl_pkg::*;

    logic [NUM_PORTS-1:0] p1_d, p2_d, p3_d, p4_d, p6_d;
    logic [NUM_PORTS-1:0] p1_q, p2_q, p3_q, p4_q, p6_q;

    logic [19:0] kp;
    logic [3:0]  kcode, jcode, line;

    // A deselected half reads as all-ones, so ANDing merges both halves.
    always_comb begin
        p1_d  = '1;
        p2_d  = '1;
        p3_d  = '1;
        p4_d  = '1;
        p6_d  = '1;
        kp    = '0;
        kcode = CODE_NONE;
        jcode = 4'b1111;
        line  = 4'b1111;
        for (int p = 0; p < NUM_PORTS; p++) begin
            kp    = keypad_i[20*p +: 20];
            kcode = ctrl_p5_i[p] ? CODE_NONE : kp_encode(kp);
            jcode = ctrl_p8_i[p] ? 4'b1111 :
                    ~{kp[KP_UP], kp[KP_DOWN], kp[KP_LEFT], kp[KP_RIGHT]};
            line    = kcode & jcode;
            p1_d[p] = line[3];
            p2_d[p] = line[2];
            p3_d[p] = line[1];
            p4_d[p] = line[0];
            p6_d[p] = (ctrl_p5_i[p] | ~kp[KP_ARM]) &
                      (ctrl_p8_i[p] | ~kp[KP_FIRE]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            p1_q <= '1;
            p2_q <= '1;
            p3_q <= '1;
            p4_q <= '1;
            p6_q <= '1;
        end else begin
            p1_q <= p1_d;
            p2_q <= p2_d;
            p3_q <= p3_d;
            p4_q <= p4_d;
            p6_q <= p6_d;
        end
    end

    assign ctrl_p1_o = p1_q;
    assign ctrl_p2_o = p2_q;
    assign ctrl_p3_o = p3_q;
    assign ctrl_p4_o = p4_q;
    assign ctrl_p6_o = p6_q;

`ifdef CV_SPINNER_EN
    logic [NUM_PORTS-1:0] a_w, b_w, fall_w;
    logic                 int_n_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_spin
        cv_spinner_quad #(
            .DELTA_W  (DELTA_W),
            .ACC_W    (ACC_W),
            .STEP_DIV (STEP_DIV)
        ) u_quad (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .ce_i      (ce_i),
            .delta_i   (spin_delta_i[g*DELTA_W +: DELTA_W]),
            .stb_i     (spin_stb_i[g]),
            .a_o       (a_w[g]),
            .b_o       (b_w[g]),
            .a_fall_o  (fall_w[g])
        );
    end

    // Registered alongside the phase flops so the pulse lines up with A falling.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            int_n_q <= 1'b1;
        else
            int_n_q <= ~|fall_w;
    end

    assign ctrl_p7_o    = a_w;
    assign ctrl_p9_o    = b_w;
    assign spin_int_n_o = int_n_q;
`else
    logic unused_spin;
    assign unused_spin  = ^{ce_i, spin_delta_i, spin_stb_i};
    assign ctrl_p7_o    = '1;
    assign ctrl_p9_o    = '1;
    assign spin_int_n_o = 1'b1;
`endif

endmodule

// File: tb/tb_cv_ctrl_port.sv
// tb_cv_ctrl_port: scoreboard bench for cv_ctrl_port against a
// behavioural reference of the key/joystick merge and the spinner.
module tb_cv_ctrl_port;

    localparam int NP  = 2;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int SD  = 4;
    localparam int KW  = 20 * NP;
    localparam int DLW = DW * NP;
    localparam int AMAX = (1 << (AW - 1)) - 1;

`ifdef CV_SPINNER_EN
    localparam bit SPIN = 1'b1;
`else
    localparam bit SPIN = 1'b0;
`endif

    localparam logic [3:0] CODE_TBL [14] = '{
        4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001, 4'b1001, 4'b0111,
        4'b1100, 4'b1000, 4'b1011, 4'b1010, 4'b0101, 4'b0100, 4'b0010};
    localparam logic [1:0] AB_TBL [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           ce = 1'b0;
    logic [KW-1:0]  keypad = '0;
    logic [DLW-1:0] spin_delta = '0;
    logic [NP-1:0]  spin_stb = '0;
    logic [NP-1:0]  ctrl_p5 = '1;
    logic [NP-1:0]  ctrl_p8 = '1;
    logic [NP-1:0]  ctrl_p1, ctrl_p2, ctrl_p3, ctrl_p4;
    logic [NP-1:0]  ctrl_p6, ctrl_p7, ctrl_p9;
    logic           spin_int_n;

    always #5 clk = ~clk;

    cv_ctrl_port #(
        .NUM_PORTS (NP),
        .DELTA_W   (DW),
        .ACC_W     (AW),
        .STEP_DIV  (SD)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .ce_i         (ce),
        .keypad_i     (keypad),
        .spin_delta_i (spin_delta),
        .spin_stb_i   (spin_stb),
        .ctrl_p5_i    (ctrl_p5),
        .ctrl_p8_i    (ctrl_p8),
        .ctrl_p1_o    (ctrl_p1),
        .ctrl_p2_o    (ctrl_p2),
        .ctrl_p3_o    (ctrl_p3),
        .ctrl_p4_o    (ctrl_p4),
        .ctrl_p6_o    (ctrl_p6),
        .ctrl_p7_o    (ctrl_p7),
        .ctrl_p9_o    (ctrl_p9),
        .spin_int_n_o (spin_int_n)
    );

    typedef struct packed {
        logic [NP-1:0] p1, p2, p3, p4, p6, p7, p9;
        logic          intn;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   int_pulses = 0;
    int   cyc = 0;

    int   acc [NP];
    int   tmr [NP];
    int   idx [NP];

    function automatic obs_t sample();
        obs_t s;
        s.p1 = ctrl_p1;
        s.p2 = ctrl_p2;
        s.p3 = ctrl_p3;
        s.p4 = ctrl_p4;
        s.p6 = ctrl_p6;
        s.p7 = ctrl_p7;
        s.p9 = ctrl_p9;
        s.intn = spin_int_n;
        return s;
    endfunction

    function automatic logic [3:0] lines(input int p);
        return {ctrl_p1[p], ctrl_p2[p], ctrl_p3[p], ctrl_p4[p]};
    endfunction

    function automatic logic [3:0] kp_ref(input logic [19:0] k);
        for (int i = 0; i < 14; i++)
            if (k[i]) return CODE_TBL[i];
        return 4'b1111;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            acc[p] = 0;
            tmr[p] = 0;
            idx[p] = 0;
        end
    endtask

    task automatic model_cycle(input logic [KW-1:0] kp,
                               input logic [NP-1:0] p5, p8,
                               input logic ce_v,
                               input logic [NP-1:0] stb,
                               input logic [DLW-1:0] dl,
                               output obs_t o);
        logic [19:0] k;
        logic [3:0]  kc, jc, l;
        logic [1:0]  ab_old, ab_new;
        logic        fall;
        bit          fire;
        int          d, dir, s;
        fall = 1'b0;
        o = '1;
        for (int p = 0; p < NP; p++) begin
            k  = kp[20*p +: 20];
            kc = p5[p] ? 4'b1111 : kp_ref(k);
            jc = p8[p] ? 4'b1111 : ~{k[14], k[15], k[16], k[17]};
            l  = kc & jc;
            o.p1[p] = l[3];
            o.p2[p] = l[2];
            o.p3[p] = l[1];
            o.p4[p] = l[0];
            o.p6[p] = (p5[p] | ~k[19]) & (p8[p] | ~k[18]);
            if (SPIN) begin
                fire = ce_v && acc[p] != 0 && tmr[p] == SD - 1;
                dir  = (acc[p] > 0) ? 1 : -1;
                if (acc[p] == 0) tmr[p] = 0;
                else if (ce_v) tmr[p] = fire ? 0 : tmr[p] + 1;
                if (fire) begin
                    ab_old = AB_TBL[idx[p]];
                    idx[p] = (idx[p] + dir + 4) % 4;
                    ab_new = AB_TBL[idx[p]];
                    if (ab_old[1] && !ab_new[1]) fall = 1'b1;
                end
                if (stb[p]) begin
                    d = $signed(dl[DW*p +: DW]);
                    s = acc[p] + d - (fire ? dir : 0);
                    if (s > AMAX) s = AMAX;
                    if (s < -AMAX) s = -AMAX;
                    acc[p] = s;
                end else if (fire) begin
                    acc[p] = acc[p] - dir;
                end
                ab_new = AB_TBL[idx[p]];
                o.p7[p] = ab_new[1];
                o.p9[p] = ab_new[0];
            end
        end
        o.intn = ~fall;
    endtask

    // Each call occupies exactly one clock; spinner inputs drop after the edge.
    task automatic drive(input logic [KW-1:0] kp,
                         input logic [NP-1:0] p5, p8,
                         input logic ce_v,
                         input logic [NP-1:0] stb,
                         input logic [DLW-1:0] dl);
        obs_t e;
        @(negedge clk);
        keypad = kp;
        ctrl_p5 = p5;
        ctrl_p8 = p8;
        ce = ce_v;
        spin_stb = stb;
        spin_delta = dl;
        model_cycle(kp, p5, p8, ce_v, stb, dl, e);
        exp_q.push_back(e);
        @(posedge clk);
        #3;
        ce = 1'b0;
        spin_stb = '0;
    endtask

    task automatic spin(input logic ce_v, input logic [NP-1:0] stb,
                        input logic [DLW-1:0] dl);
        drive('0, '1, '1, ce_v, stb, dl);
    endtask

    task automatic check_val(input string name, input logic [7:0] got,
                             input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_pulse();
        obs_t s;
        drain();
        @(negedge clk);
        ce = 1'b0;
        spin_stb = '0;
        reset_n = 1'b0;
        #1;
        s = sample();
        checks++;
        if (s !== '1) begin
            errors++;
            $display("FAIL reset_outs: got %h want %h", s, {$bits(obs_t){1'b1}});
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        obs_t e, g;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (reset_n && spin_int_n === 1'b0) int_pulses++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = sample();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL lines cyc %0d: got %h want %h", cyc, g, e);
                end
            end
        end
    end

    logic [KW-1:0]  kv;
    logic [NP-1:0]  sv;
    logic [DLW-1:0] dv;
    int             base;

    initial begin : stim
        model_reset();
        #12;
        check_val("reset_init", 8'(sample()), 8'(obs_t'('1)));
        check_val("reset_int", 8'(spin_int_n), 8'h01);
        @(negedge clk);
        reset_n = 1'b1;

        kv = '0;
        kv[20 + 3] = 1'b1;
        kv[20 + 7] = 1'b1;
        drive(kv, 2'b01, 2'b11, 1'b0, '0, '0);
        check_val("kp_p1_3and7", 8'(lines(1)), 8'h06);
        check_val("kp_p0_idle", 8'(lines(0)), 8'h0f);
        kv[20 + 3] = 1'b0;
        drive(kv, 2'b01, 2'b11, 1'b0, '0, '0);
        check_val("kp_p1_7", 8'(lines(1)), 8'h0c);

        kv = '0;
        kv[8] = 1'b1;
        kv[14] = 1'b1;
        kv[18] = 1'b1;
        kv[19] = 1'b1;
        drive(kv, 2'b10, 2'b10, 1'b0, '0, '0);
        check_val("merge_lines", 8'(lines(0)), 8'h00);
        check_val("merge_p6", 8'(ctrl_p6[0]), 8'h00);

        for (int i = 0; i < 300; i++) begin
            kv = KW'({$urandom(), $urandom()} & {$urandom(), $urandom()} &
                     {$urandom(), $urandom()});
            drive(kv, NP'($urandom_range(0, 3)), NP'($urandom_range(0, 3)),
                  1'b0, '0, '0);
        end

`ifdef CV_SPINNER_EN
        spin(1'b0, 2'b01, DLW'(3));
        base = int_pulses;
        repeat (16) spin(1'b1, '0, '0);
        check_val("plus3_pulses", 8'(int_pulses - base), 8'd1);
        check_val("plus3_phase", 8'({ctrl_p7[0], ctrl_p9[0]}), 8'h01);

        spin(1'b0, 2'b01, DLW'(2));
        repeat (3) spin(1'b1, '0, '0);
        spin(1'b1, 2'b01, DLW'(8'hff));
        repeat (20) spin(1'b1, '0, '0);
        check_val("coincide_phase", 8'({ctrl_p7[0], ctrl_p9[0]}), 8'h03);

        repeat (3) spin(1'b0, 2'b01, DLW'(127));
        base = int_pulses;
        repeat (127 * SD + 12) spin(1'b1, '0, '0);
        check_val("clamp_phase", 8'({ctrl_p7[0], ctrl_p9[0]}), 8'h01);
        check_val("clamp_pulses", 8'(int_pulses - base), 8'd32);

        spin(1'b0, 2'b01, DLW'(5));
        repeat (6) spin(1'b1, '0, '0);
        reset_pulse();
        base = int_pulses;
        repeat (40) spin(1'b1, '0, '0);
        check_val("post_reset_phase", 8'({ctrl_p7[0], ctrl_p9[0]}), 8'h03);
        check_val("post_reset_pulses", 8'(int_pulses - base), 8'd0);
`else
        spin(1'b0, 2'b11, DLW'(16'h0505));
        base = int_pulses;
        repeat (40) spin(1'b1, '0, '0);
        check_val("off_p7p9", 8'({ctrl_p7, ctrl_p9}), 8'h0f);
        check_val("off_pulses", 8'(int_pulses - base), 8'd0);
        reset_pulse();
`endif

        for (int i = 0; i < 2000; i++) begin
            kv = KW'({$urandom(), $urandom()} & {$urandom(), $urandom()} &
                     {$urandom(), $urandom()});
            for (int p = 0; p < NP; p++) begin
                sv[p] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0)
                    dv[DW*p +: DW] = DW'($urandom());
                else
                    dv[DW*p +: DW] = DW'($urandom_range(0, 8) - 4);
            end
            drive(kv, NP'($urandom_range(0, 3)), NP'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), sv, dv);
        end

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
